alu: RTL and testbench
======================

# alu

Single-cycle MIPS-subset arithmetic/logic unit for the datapath execute stage. It decodes the raw 32-bit instruction word into an ALU control code and selects operands. Results and flags (`c`, `zero`, `overflow`, `neg`) are computed combinationally. Multiply/divide results are also latched into HI/LO registers on the clock.

## Interface
- No parameters. Datapath width is fixed at 32.
- `clk` input 1: rising-edge clock, used only by HI/LO.
- `rst_n` input 1: asynchronous, active-low reset.
- `i_datain` input 32: instruction word. op=[31:26], rs=[25:21], rt=[20:16], shamt=[10:6], func=[5:0], imm=[15:0].
- `gr1` input 32: rs register value.
- `gr2` input 32: rt register value.
- `c` output 32: combinational result.
- `zero` output 1: high when c==0.
- `overflow` output 1: signed overflow, only for add, sub and addi.
- `neg` output 1: equal to c[31].
- `hi` output 32: registered HI.
- `lo` output 32: registered LO.
- Required internal signals, probed hierarchically by benches: `op[5:0]`, `func[5:0]`, `ALUCr[3:0]`, `reg_a[31:0]`, `reg_b[31:0]`.

## Operation
- ALUCr codes: 0 and, 1 or, 2 add, 3 xor, 4 nor, 5 sll, 6 sub, 7 slt, 8 sltu, 9 srl, A sra, B mult, C multu, D div, E divu, F unsupported.
- R-type, op=0, decoded by func:
  - Arithmetic: add 20, addu 21, sub 22, subu 23.
  - Logic: and 24, or 25, xor 26, nor 27.
  - Compare: slt 2A, sltu 2B.
  - Fixed shifts: sll 00, srl 02, sra 03.
  - Variable shifts: sllv 04, srlv 06, srav 07.
  - Mult/div: mult 18, multu 19, div 1A, divu 1B.
- I-type, decoded by op:
  - addi 08, addiu 09, slti 0A, sltiu 0B.
  - andi 0C, ori 0D, xori 0E.
  - beq 04, bne 05, lw 23, sw 2B.
- Operand selection:
  - Default: reg_a=gr1, reg_b=gr2.
  - Fixed shifts: reg_a=gr2, reg_b=zero-extended shamt.
  - Variable shifts: reg_a=gr1, reg_b=zero-extended gr2[4:0].
  - addi, addiu, slti, sltiu, lw, sw: reg_b=sign-extended imm.
  - andi, ori, xori: reg_b=zero-extended imm.
- Results:
  - Shifts: c = reg_a shifted by reg_b[4:0]. sra/srav fill with reg_a[31].
  - slt/slti compare signed; sltu/sltiu compare unsigned. Both give c=1 or 0.
  - beq/bne: c = gr1 - gr2. Branch decision is `zero`.
  - lw/sw: c = gr1 + sext(imm).
  - mult/multu: c = low word of the 64-bit product.
  - div/divu: c = quotient.
- Overflow: set only for add, sub, addi, using the sign rule (operand signs vs result sign). It is 0 for all other ops, including addu/subu/addiu.
- Divide by zero: c=FFFFFFFF. On the edge, LO=FFFFFFFF and HI=gr1.
- Unsupported op/func: ALUCr=F, c=0, zero=1, overflow=0, neg=0. HI/LO unchanged.

## Timing
- c, zero, overflow, neg, ALUCr, reg_a and reg_b are purely combinational from i_datain/gr1/gr2. Zero-cycle latency.
- HI/LO update on rising clk while ALUCr is in B–E:
  - mult/multu: HI=product[63:32], LO=product[31:0].
  - div/divu: LO=quotient, HI=remainder. Signed division truncates toward zero; the remainder takes the dividend's sign.
- For any other instruction, HI/LO hold their value.
- rst_n low clears HI/LO to 0 immediately, regardless of clk, and holds them at 0 while low. Release is synchronous to the next edge. Combinational outputs are unaffected by reset.

## Structure
- Shared package `alu_pkg`: opcode and func constants, the ALUCr enumeration, and the signed-overflow flag rule.
- Natural sub-module: `alu_decode`, containing op/func → ALUCr, immediate extension and reg_a/reg_b mux.
- Kept in the top: datapath, multiplier/divider and HI/LO registers.

## Test plan
- sll, i_datain=00011040 (shamt 1), gr2=DDDDDDDD -> c=BBBBBBBA.
- sra, i_datain=00011083 (shamt 2), gr2=DDDDDDDD -> c=F7777777, neg=1.
- add, gr1=7FFFFFFF, gr2=00000001:
  - add -> c=80000000, overflow=1, neg=1.
  - same operands with addu -> overflow=0.
- addi, gr1=FFFFFFFF, imm=8000 -> c=FFFF7FFF.
- andi, same gr1 and imm -> c=00008000.
- beq, gr1=gr2=00AFAD80 -> c=0, zero=1.
- beq, gr2=00AFAD88 -> zero=0, neg=1.
- mult with gr1=FFFFFFFE, gr2=3:
  - mult: c=FFFFFFFA; after the edge HI=FFFFFFFF, LO=FFFFFFFA.
  - multu: HI=00000002, LO=FFFFFFFA.
  - Pulling rst_n low mid-cycle clears HI/LO to 0 at once.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/func constants, ALU control enumeration and the signed-overflow rule
// for the MIPS-subset execute-stage ALU.
package alu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [3:0] {
        ALU_AND   = 4'h0,
        ALU_OR    = 4'h1,
        ALU_ADD   = 4'h2,
        ALU_XOR   = 4'h3,
        ALU_NOR   = 4'h4,
        ALU_SLL   = 4'h5,
        ALU_SUB   = 4'h6,
        ALU_SLT   = 4'h7,
        ALU_SLTU  = 4'h8,
        ALU_SRL   = 4'h9,
        ALU_SRA   = 4'hA,
        ALU_MULT  = 4'hB,
        ALU_MULTU = 4'hC,
        ALU_DIV   = 4'hD,
        ALU_DIVU  = 4'hE,
        ALU_BAD   = 4'hF
    } alucr_e;

    // Subtraction flips the effective sign of b; overflow when equal-signed inputs
    // produce a result of the opposite sign.
    function automatic logic signed_ovf(input logic a_s, input logic b_s,
                                        input logic r_s, input logic is_sub);
        logic b_eff;
        b_eff = b_s ^ is_sub;
        return (a_s == b_eff) && (r_s != a_s);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Instruction decode: op/func to ALU control code, immediate extension and
// operand selection for the execute stage.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] gr1_i,
    input  logic [31:0] gr2_i,
    output alucr_e      alucr_o,
    output logic [31:0] reg_a_o,
    output logic [31:0] reg_b_o,
    output logic        ovf_chk_o
);

    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] shamt_z;
    logic [31:0] vshift_z;
    logic [31:0] imm_s;
    logic [31:0] imm_z;
    logic        unused_fields;

    assign op            = instr_i[31:26];
    assign func          = instr_i[5:0];
    assign shamt_z       = {27'd0, instr_i[10:6]};
    assign vshift_z      = {27'd0, gr2_i[4:0]};
    assign imm_s         = {{16{instr_i[15]}}, instr_i[15:0]};
    assign imm_z         = {16'd0, instr_i[15:0]};
    assign unused_fields = ^instr_i[25:11];

    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        alucr_o   = ALU_BAD;
        reg_a_o   = gr1_i;
        reg_b_o   = gr2_i;
        ovf_chk_o = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                unique case (func)
                    FN_ADD:   begin alucr_o = ALU_ADD; ovf_chk_o = 1'b1; end
                    FN_ADDU:  alucr_o = ALU_ADD;
                    FN_SUB:   begin alucr_o = ALU_SUB; ovf_chk_o = 1'b1; end
                    FN_SUBU:  alucr_o = ALU_SUB;
                    FN_AND:   alucr_o = ALU_AND;
                    FN_OR:    alucr_o = ALU_OR;
                    FN_XOR:   alucr_o = ALU_XOR;
                    FN_NOR:   alucr_o = ALU_NOR;
                    FN_SLT:   alucr_o = ALU_SLT;
                    FN_SLTU:  alucr_o = ALU_SLTU;
                    FN_SLL:   begin alucr_o = ALU_SLL; reg_a_o = gr2_i; reg_b_o = shamt_z; end
                    FN_SRL:   begin alucr_o = ALU_SRL; reg_a_o = gr2_i; reg_b_o = shamt_z; end
                    FN_SRA:   begin alucr_o = ALU_SRA; reg_a_o = gr2_i; reg_b_o = shamt_z; end
                    FN_SLLV:  begin alucr_o = ALU_SLL; reg_b_o = vshift_z; end
                    FN_SRLV:  begin alucr_o = ALU_SRL; reg_b_o = vshift_z; end
                    FN_SRAV:  begin alucr_o = ALU_SRA; reg_b_o = vshift_z; end
                    FN_MULT:  alucr_o = ALU_MULT;
                    FN_MULTU: alucr_o = ALU_MULTU;
                    FN_DIV:   alucr_o = ALU_DIV;
                    FN_DIVU:  alucr_o = ALU_DIVU;
                    default:  alucr_o = ALU_BAD;
                endcase
            end
            OP_ADDI:  begin alucr_o = ALU_ADD;  reg_b_o = imm_s; ovf_chk_o = 1'b1; end
            OP_ADDIU: begin alucr_o = ALU_ADD;  reg_b_o = imm_s; end
            OP_SLTI:  begin alucr_o = ALU_SLT;  reg_b_o = imm_s; end
            OP_SLTIU: begin alucr_o = ALU_SLTU; reg_b_o = imm_s; end
            OP_LW,
            OP_SW:    begin alucr_o = ALU_ADD;  reg_b_o = imm_s; end
            OP_ANDI:  begin alucr_o = ALU_AND;  reg_b_o = imm_z; end
            OP_ORI:   begin alucr_o = ALU_OR;   reg_b_o = imm_z; end
            OP_XORI:  begin alucr_o = ALU_XOR;  reg_b_o = imm_z; end
            OP_BEQ,
            OP_BNE:   alucr_o = ALU_SUB;
            default:  alucr_o = ALU_BAD;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Single-cycle MIPS-subset ALU: combinational result and flags, with multiply and
// divide results captured into HI/LO on the clock.
module alu
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_datain,
    input  logic [31:0] gr1,
    input  logic [31:0] gr2,
    output logic [31:0] c,
    output logic        zero,
    output logic        overflow,
    output logic        neg,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [5:0]         op;
    logic [5:0]         func;
    logic [3:0]         ALUCr;
    logic [31:0]        reg_a;
    logic [31:0]        reg_b;
    alucr_e             alucr;
    logic               ovf_chk;

    logic [31:0]        sum;
    logic [31:0]        diff;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               div_zero;
    logic [31:0]        div_b;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
    logic [31:0]        hi_d, hi_q;
    logic [31:0]        lo_d, lo_q;

    assign op   = i_datain[31:26];
    assign func = i_datain[5:0];

    alu_decode u_decode (
        .instr_i   (i_datain),
        .gr1_i     (gr1),
        .gr2_i     (gr2),
        .alucr_o   (alucr),
        .reg_a_o   (reg_a),
        .reg_b_o   (reg_b),
        .ovf_chk_o (ovf_chk)
    );

    assign ALUCr = alucr;

    assign sum    = reg_a + reg_b;
    assign diff   = reg_a - reg_b;
    assign prod_s = $signed({{32{reg_a[31]}}, reg_a}) * $signed({{32{reg_b[31]}}, reg_b});
    assign prod_u = {32'd0, reg_a} * {32'd0, reg_b};

    // A zero divisor is replaced by 1 so the dividers never see it; the result
    // is overridden below.
    assign div_zero = (reg_b == 32'd0);
    assign div_b    = div_zero ? 32'd1 : reg_b;
    assign quot_s   = $signed(reg_a) / $signed(div_b);
    assign rem_s    = $signed(reg_a) % $signed(div_b);
    assign quot_u   = reg_a / div_b;
    assign rem_u    = reg_a % div_b;

    always_comb begin
        c    = 32'd0;
        hi_d = hi_q;
        lo_d = lo_q;
        unique case (alucr)
            ALU_AND:   c = reg_a & reg_b;
            ALU_OR:    c = reg_a | reg_b;
            ALU_ADD:   c = sum;
            ALU_XOR:   c = reg_a ^ reg_b;
            ALU_NOR:   c = ~(reg_a | reg_b);
            ALU_SLL:   c = reg_a << reg_b[4:0];
            ALU_SUB:   c = diff;
            ALU_SLT:   c = {31'd0, $signed(reg_a) < $signed(reg_b)};
            ALU_SLTU:  c = {31'd0, reg_a < reg_b};
            ALU_SRL:   c = reg_a >> reg_b[4:0];
            ALU_SRA:   c = $signed(reg_a) >>> reg_b[4:0];
            ALU_MULT:  begin c = prod_s[31:0]; hi_d = prod_s[63:32]; lo_d = prod_s[31:0]; end
            ALU_MULTU: begin c = prod_u[31:0]; hi_d = prod_u[63:32]; lo_d = prod_u[31:0]; end
            ALU_DIV: begin
                c    = div_zero ? 32'hFFFF_FFFF : quot_s;
                lo_d = c;
                hi_d = div_zero ? reg_a : rem_s;
            end
            ALU_DIVU: begin
                c    = div_zero ? 32'hFFFF_FFFF : quot_u;
                lo_d = c;
                hi_d = div_zero ? reg_a : rem_u;
            end
            default:   c = 32'd0;
        endcase
    end

    assign zero     = (c == 32'd0);
    assign neg      = c[31];
    assign overflow = ovf_chk & signed_ovf(reg_a[31], reg_b[31], c[31], alucr == ALU_SUB);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; HI/LO are the only state here and both take the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: the driver queues expected values, a monitor
// pops and compares them each time the driver strobes a sample point.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] i_datain;
    logic [31:0] gr1;
    logic [31:0] gr2;
    logic [31:0] c;
    logic        zero;
    logic        overflow;
    logic        neg;
    logic [31:0] hi;
    logic [31:0] lo;

    alu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_datain (i_datain),
        .gr1      (gr1),
        .gr2      (gr2),
        .c        (c),
        .zero     (zero),
        .overflow (overflow),
        .neg      (neg),
        .hi       (hi),
        .lo       (lo)
    );

    typedef enum int {S_C, S_ZERO, S_OVF, S_NEG, S_HI, S_LO, S_ALUCR} sel_e;

    typedef struct {
        string       name;
        sel_e        sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    event chk_ev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input sel_e s);
        case (s)
            S_C:     return c;
            S_ZERO:  return {31'd0, zero};
            S_OVF:   return {31'd0, overflow};
            S_NEG:   return {31'd0, neg};
            S_HI:    return hi;
            S_LO:    return lo;
            default: return {28'd0, dut.ALUCr};
        endcase
    endfunction

    // Monitor: drains every expectation queued before the strobe.
    initial begin
        forever begin
            @(chk_ev);
            while (sb_q.size() > 0) begin
                exp_t e;
                logic [31:0] a;
                e = sb_q.pop_front();
                a = actual(e.sel);
                total++;
                if (a !== e.val) begin
                    bad++;
                    $display("FAIL %s: got %08h expected %08h", e.name, a, e.val);
                end
            end
        end
    end

    task automatic expect_v(input string n, input sel_e s, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sel  = s;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic strobe();
        #1;
        -> chk_ev;
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
        i_datain = instr;
        gr1      = a;
        gr2      = b;
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        i_datain = 32'd0;
        gr1      = 32'd0;
        gr2      = 32'd0;
        #3;
        expect_v("reset_hi", S_HI, 32'd0);
        expect_v("reset_lo", S_LO, 32'd0);
        strobe();
        @(negedge clk);
        rst_n = 1'b1;

        drive(32'h0001_1040, 32'd0, 32'hDDDD_DDDD);
        expect_v("sll_c", S_C, 32'hBBBB_BBBA);
        expect_v("sll_alucr", S_ALUCR, 32'h5);
        strobe();

        drive(32'h0001_1083, 32'd0, 32'hDDDD_DDDD);
        expect_v("sra_c", S_C, 32'hF777_7777);
        expect_v("sra_neg", S_NEG, 32'd1);
        strobe();

        drive(32'h0000_0020, 32'h7FFF_FFFF, 32'h0000_0001);
        expect_v("add_c", S_C, 32'h8000_0000);
        expect_v("add_ovf", S_OVF, 32'd1);
        expect_v("add_neg", S_NEG, 32'd1);
        strobe();

        drive(32'h0000_0021, 32'h7FFF_FFFF, 32'h0000_0001);
        expect_v("addu_c", S_C, 32'h8000_0000);
        expect_v("addu_ovf", S_OVF, 32'd0);
        strobe();

        drive(32'h0000_0022, 32'h8000_0000, 32'h0000_0001);
        expect_v("sub_c", S_C, 32'h7FFF_FFFF);
        expect_v("sub_ovf", S_OVF, 32'd1);
        strobe();

        drive(32'h2000_8000, 32'hFFFF_FFFF, 32'd0);
        expect_v("addi_c", S_C, 32'hFFFF_7FFF);
        expect_v("addi_ovf", S_OVF, 32'd0);
        strobe();

        drive(32'h3000_8000, 32'hFFFF_FFFF, 32'd0);
        expect_v("andi_c", S_C, 32'h0000_8000);
        strobe();

        drive(32'h3800_00FF, 32'hFFFF_0F0F, 32'd0);
        expect_v("xori_c", S_C, 32'hFFFF_0FF0);
        strobe();

        drive(32'h0000_0027, 32'h0F0F_0F0F, 32'h00FF_00FF);
        expect_v("nor_c", S_C, 32'hF000_F000);
        strobe();

        drive(32'h0000_002A, 32'hFFFF_FFFF, 32'h0000_0001);
        expect_v("slt_c", S_C, 32'd1);
        strobe();

        drive(32'h0000_002B, 32'hFFFF_FFFF, 32'h0000_0001);
        expect_v("sltu_c", S_C, 32'd0);
        expect_v("sltu_zero", S_ZERO, 32'd1);
        strobe();

        drive(32'h2C00_FFFF, 32'h0000_0005, 32'd0);
        expect_v("sltiu_c", S_C, 32'd1);
        strobe();

        drive(32'h0000_0007, 32'h8000_0000, 32'h0000_0004);
        expect_v("srav_c", S_C, 32'hF800_0000);
        strobe();

        drive(32'h8C00_FFFC, 32'h0000_0100, 32'd0);
        expect_v("lw_c", S_C, 32'h0000_00FC);
        strobe();

        drive(32'h1000_0000, 32'h00AF_AD80, 32'h00AF_AD80);
        expect_v("beq_eq_c", S_C, 32'd0);
        expect_v("beq_eq_zero", S_ZERO, 32'd1);
        strobe();

        drive(32'h1000_0000, 32'h00AF_AD80, 32'h00AF_AD88);
        expect_v("beq_ne_zero", S_ZERO, 32'd0);
        expect_v("beq_ne_neg", S_NEG, 32'd1);
        strobe();

        // Multiply/divide: combinational result now, HI/LO after the edge.
        @(negedge clk);
        drive(32'h0000_0018, 32'hFFFF_FFFE, 32'h0000_0003);
        expect_v("mult_c", S_C, 32'hFFFF_FFFA);
        strobe();
        @(posedge clk);
        expect_v("mult_hi", S_HI, 32'hFFFF_FFFF);
        expect_v("mult_lo", S_LO, 32'hFFFF_FFFA);
        strobe();

        @(negedge clk);
        drive(32'h0000_001A, 32'hFFFF_FFF9, 32'h0000_0002);
        expect_v("div_c", S_C, 32'hFFFF_FFFD);
        strobe();
        @(posedge clk);
        expect_v("div_hi", S_HI, 32'hFFFF_FFFF);
        expect_v("div_lo", S_LO, 32'hFFFF_FFFD);
        strobe();

        @(negedge clk);
        drive(32'h0000_001B, 32'h0000_0007, 32'h0000_0002);
        @(posedge clk);
        expect_v("divu_hi", S_HI, 32'h0000_0001);
        expect_v("divu_lo", S_LO, 32'h0000_0003);
        strobe();

        @(negedge clk);
        drive(32'h0000_001A, 32'h1234_5678, 32'd0);
        expect_v("div0_c", S_C, 32'hFFFF_FFFF);
        strobe();
        @(posedge clk);
        expect_v("div0_hi", S_HI, 32'h1234_5678);
        expect_v("div0_lo", S_LO, 32'hFFFF_FFFF);
        strobe();

        @(negedge clk);
        drive(32'hFC00_0000, 32'h1111_1111, 32'h2222_2222);
        expect_v("bad_c", S_C, 32'd0);
        expect_v("bad_zero", S_ZERO, 32'd1);
        expect_v("bad_neg", S_NEG, 32'd0);
        expect_v("bad_alucr", S_ALUCR, 32'hF);
        strobe();
        @(posedge clk);
        expect_v("bad_hold_hi", S_HI, 32'h1234_5678);
        expect_v("bad_hold_lo", S_LO, 32'hFFFF_FFFF);
        strobe();

        @(negedge clk);
        drive(32'h0000_0019, 32'hFFFF_FFFE, 32'h0000_0003);
        @(posedge clk);
        expect_v("multu_hi", S_HI, 32'h0000_0002);
        expect_v("multu_lo", S_LO, 32'hFFFF_FFFA);
        strobe();

        // Mid-cycle asynchronous reset clears HI/LO without a clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        expect_v("async_rst_hi", S_HI, 32'd0);
        expect_v("async_rst_lo", S_LO, 32'd0);
        strobe();
        @(posedge clk);
        expect_v("rst_hold_lo", S_LO, 32'd0);
        strobe();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 100 && sb_q.size() > 0; i++) #1;
        if (sb_q.size() > 0) begin
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
            bad += sb_q.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
